// File: rtl/chameleon_topk_pkg.sv
// Shared types and helpers for the streaming top-K classifier head.
package chameleon_topk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } topk_state_t;

    // Bits needed to hold a fill count of 0..k.
    function automatic int unsigned clog2_k(input int unsigned k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/topk_insert.sv
// Combinational sorted insert of one candidate into a K-entry non-increasing list.
module topk_insert
    import chameleon_topk_pkg::*;
#(
    parameter int unsigned VW        = 8,
    parameter int unsigned K         = 3,
    parameter int unsigned IDX_WIDTH = 6,
    localparam int unsigned CW       = clog2_k(K)
) (
    input  logic [K*VW-1:0]        val_i,
    input  logic [K*IDX_WIDTH-1:0] idx_i,
    input  logic [CW-1:0]          cnt_i,
    input  logic [VW-1:0]          cand_val_i,
    input  logic [IDX_WIDTH-1:0]   cand_idx_i,
    output logic [K*VW-1:0]        val_c,
    output logic [K*IDX_WIDTH-1:0] idx_c,
    output logic [CW-1:0]          cnt_c
);

    // take[p]: candidate belongs at or above slot p; monotonic because the list is sorted
    // and empty slots are judged by count, so a minimum-valued candidate still fills them.
    logic [K-1:0] take;

    always_comb begin
        take = '0;
        for (int p = 0; p < K; p++) begin
            take[p] = (CW'(p) >= cnt_i) ||
                      ($signed(cand_val_i) > $signed(val_i[p*VW +: VW]));
        end
    end

    always_comb begin
        val_c = val_i;
        idx_c = idx_i;
        if (take[0]) begin
            val_c[0 +: VW]        = cand_val_i;
            idx_c[0 +: IDX_WIDTH] = cand_idx_i;
        end
        for (int j = 1; j < K; j++) begin
            if (take[j]) begin
                if (take[j-1]) begin
                    val_c[j*VW +: VW]               = val_i[(j-1)*VW +: VW];
                    idx_c[j*IDX_WIDTH +: IDX_WIDTH] = idx_i[(j-1)*IDX_WIDTH +: IDX_WIDTH];
                end else begin
                    val_c[j*VW +: VW]               = cand_val_i;
                    idx_c[j*IDX_WIDTH +: IDX_WIDTH] = cand_idx_i;
                end
            end
        end
        cnt_c = (cnt_i < CW'(K)) ? cnt_i + CW'(1) : cnt_i;
    end

endmodule

// File: rtl/serial_parallel_topk.sv
// Streaming top-K head: latches N-lane beats, scans one lane per cycle into a sorted list,
// and presents the K largest values with their global class indices at frame end.
module serial_parallel_topk
    import chameleon_topk_pkg::*;
#(
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned N                = 8,
    parameter int unsigned K                = 3,
    parameter int unsigned IDX_WIDTH        = 6,
    parameter int unsigned INPUT_DATA_SHIFT = 0,
    parameter int unsigned LEFT_SHIFT_WIDTH = 2,
    localparam int unsigned VW              = WIDTH - INPUT_DATA_SHIFT,
    localparam int unsigned CW              = clog2_k(K)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [LEFT_SHIFT_WIDTH-1:0] inputs_left_shift,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [N*WIDTH-1:0]          data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [K*IDX_WIDTH-1:0]      topk_idx,
    output logic [K*VW-1:0]             topk_val,
    output logic [CW-1:0]               topk_count,
    output logic                        idx_overflow
);

    localparam int unsigned LW = $clog2(N);
    localparam int unsigned BW = IDX_WIDTH - LW;
    localparam logic [VW-1:0] VMIN = {1'b1, {(VW-1){1'b0}}};

    if (K > N || K < 1) begin : g_bad_k
        $error("serial_parallel_topk: K must be in 1..N");
    end

    topk_state_t state_q, state_d;

    logic [N*VW-1:0]          lanes_q, lanes_d;
    logic                     last_q, last_d;
    logic [LW-1:0]            lane_q, lane_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic [K*VW-1:0]          val_q, val_d;
    logic [K*IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;

    logic [N*VW-1:0]          scaled_c;
    logic [VW-1:0]            cand_val_c;
    logic [IDX_WIDTH-1:0]     cand_idx_c;
    logic [K*VW-1:0]          ins_val_c;
    logic [K*IDX_WIDTH-1:0]   ins_idx_c;
    logic [CW-1:0]            ins_cnt_c;
    logic                     lane_end_c;

    // Left shift wraps inside WIDTH bits before the fixed arithmetic right shift.
    always_comb begin
        scaled_c = '0;
        for (int i = 0; i < N; i++) begin
            scaled_c[i*VW +: VW] =
                VW'($signed(WIDTH'(data[i*WIDTH +: WIDTH] << inputs_left_shift)) >>> INPUT_DATA_SHIFT);
        end
    end

    assign cand_val_c = lanes_q[lane_q*VW +: VW];
    assign cand_idx_c = {beat_q, lane_q};
    assign lane_end_c = (lane_q == LW'(N - 1));

    topk_insert #(
        .VW        (VW),
        .K         (K),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_insert (
        .val_i      (val_q),
        .idx_i      (idx_q),
        .cnt_i      (cnt_q),
        .cand_val_i (cand_val_c),
        .cand_idx_i (cand_idx_c),
        .val_c      (ins_val_c),
        .idx_c      (ins_idx_c),
        .cnt_c      (ins_cnt_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid)   state_d = SCAN;
                SCAN:    if (lane_end_c) state_d = last_q ? DONE : IDLE;
                DONE:    if (out_ready)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        lanes_d     = lanes_q;
        last_d      = last_q;
        lane_d      = lane_q;
        beat_d      = beat_q;
        val_d       = val_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        if (clear || (state_q == DONE && out_ready)) begin
            val_d  = {K{VMIN}};
            idx_d  = '0;
            cnt_d  = '0;
            beat_d = '0;
            ovf_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        lanes_d = scaled_c;
                        last_d  = in_last;
                        lane_d  = '0;
                    end
                end
                SCAN: begin
                    val_d  = ins_val_c;
                    idx_d  = ins_idx_c;
                    cnt_d  = ins_cnt_c;
                    lane_d = lane_q + LW'(1);
                    if (lane_end_c) begin
                        beat_d = beat_q + BW'(1);
                        if (beat_q == {BW{1'b1}}) ovf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q     <= '0;
            last_q      <= 1'b0;
            lane_q      <= '0;
            beat_q      <= '0;
            val_q       <= {K{VMIN}};
            idx_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            lanes_q     <= lanes_d;
            last_q      <= last_d;
            lane_q      <= lane_d;
            beat_q      <= beat_d;
            val_q       <= val_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign topk_idx     = idx_q;
    assign topk_val     = val_q;
    assign topk_count   = cnt_q;
    assign idx_overflow = ovf_q;

endmodule
